// File: rtl/ex_seg.sv
// Purpose : EX stage of a 5-stage MIPS-style pipeline; ALU, branch/jump resolution, EX/MEM register.
// Latency : 1 cycle, inputs sampled on every rising clk edge, new result every cycle.
// Backpr. : none; no stall or enable input, the stage always advances.
//
// Ports:
//   clk   - rising-edge pipeline clock
//   rst   - asynchronous active-low reset, clears every output register
//   IRi   - instruction from ID (op=[31:26], shamt=[10:6], funct=[5:0], imm=[15:0], target=[25:0])
//   NPCi  - PC+4 of this instruction
//   Ai/Bi - rs / rt register values
//   Immi  - sign-extended imm16 from ID
//   cond  - registered branch/jump-taken flag
//   ALUo  - registered ALU result, memory address or branch/jump target
//   Bo    - registered store data, or link value for jal
//   IRo   - registered copy of IRi
module ex_seg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IRi,
    input  logic [31:0] NPCi,
    input  logic [31:0] Ai,
    input  logic [31:0] Bi,
    input  logic [31:0] Immi,
    output logic        cond,
    output logic [31:0] ALUo,
    output logic [31:0] Bo,
    output logic [31:0] IRo
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  vshamt;
    logic [31:0] zimm;

    assign op     = IRi[31:26];
    assign funct  = IRi[5:0];
    assign shamt  = IRi[10:6];
    assign vshamt = Ai[4:0];
    assign zimm   = {16'h0000, IRi[15:0]};

    logic        cond_d, cond_q;
    logic [31:0] alu_d,  alu_q;
    logic [31:0] bo_d,   bo_q;
    logic [31:0] ir_d,   ir_q;

    always_comb begin
        alu_d  = 32'h0;
        cond_d = 1'b0;
        bo_d   = Bi;
        ir_d   = IRi;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    // The all-zero word is the canonical nop and always yields 0,
                    // regardless of what the register file put on Bi.
                    F_SLL:  alu_d = (IRi == 32'h0) ? 32'h0 : (Bi << shamt);
                    F_SRL:  alu_d = Bi >> shamt;
                    F_SRA:  alu_d = $unsigned($signed(Bi) >>> shamt);
                    F_SLLV: alu_d = Bi << vshamt;
                    F_SRLV: alu_d = Bi >> vshamt;
                    F_SRAV: alu_d = $unsigned($signed(Bi) >>> vshamt);
                    F_JR: begin
                        alu_d  = Ai;
                        cond_d = 1'b1;
                    end
                    F_ADD, F_ADDU: alu_d = Ai + Bi;
                    F_SUB, F_SUBU: alu_d = Ai - Bi;
                    F_AND:  alu_d = Ai & Bi;
                    F_OR:   alu_d = Ai | Bi;
                    F_XOR:  alu_d = Ai ^ Bi;
                    F_NOR:  alu_d = ~(Ai | Bi);
                    F_SLT:  alu_d = {31'h0, ($signed(Ai) < $signed(Bi))};
                    F_SLTU: alu_d = {31'h0, (Ai < Bi)};
                    default: alu_d = 32'h0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_d = Ai + Immi;
            OP_SLTI:  alu_d = {31'h0, ($signed(Ai) < $signed(Immi))};
            OP_SLTIU: alu_d = {31'h0, (Ai < Immi)};
            // Logical immediates are zero-extended, so Immi is not used here.
            OP_ANDI:  alu_d = Ai & zimm;
            OP_ORI:   alu_d = Ai | zimm;
            OP_XORI:  alu_d = Ai ^ zimm;
            OP_LUI:   alu_d = {IRi[15:0], 16'h0000};
            OP_BEQ: begin
                alu_d  = NPCi + (Immi << 2);
                cond_d = (Ai == Bi);
            end
            OP_BNE: begin
                alu_d  = NPCi + (Immi << 2);
                cond_d = (Ai != Bi);
            end
            OP_J: begin
                alu_d  = {NPCi[31:28], IRi[25:0], 2'b00};
                cond_d = 1'b1;
            end
            OP_JAL: begin
                alu_d  = {NPCi[31:28], IRi[25:0], 2'b00};
                cond_d = 1'b1;
                bo_d   = NPCi;  // link value travels down the B path to writeback
            end
            default: begin
                alu_d  = 32'h0;
                cond_d = 1'b0;
            end
        endcase
    end

    // EX/MEM pipeline register; reset clears it immediately, dropping any in-flight result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cond_q <= 1'b0;
            alu_q  <= 32'h0;
            bo_q   <= 32'h0;
            ir_q   <= 32'h0;
        end else begin
            cond_q <= cond_d;
            alu_q  <= alu_d;
            bo_q   <= bo_d;
            ir_q   <= ir_d;
        end
    end

    assign cond = cond_q;
    assign ALUo = alu_q;
    assign Bo   = bo_q;
    assign IRo  = ir_q;

endmodule

// File: tb/tb_ex_seg.sv
// Purpose : self-checking bench for ex_seg with an expected-result queue.
// Latency : expects every result exactly one rising edge after its inputs are driven.
// Backpr. : none; stimulus is issued one instruction per cycle.
module tb_ex_seg;

    logic        clk;
    logic        rst;
    logic [31:0] IRi, NPCi, Ai, Bi, Immi;
    logic        cond;
    logic [31:0] ALUo, Bo, IRo;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic        cnd;
        logic [31:0] bo;
        logic [31:0] ir;
    } exp_t;

    exp_t sb_q[$];

    ex_seg dut (
        .clk  (clk),
        .rst  (rst),
        .IRi  (IRi),
        .NPCi (NPCi),
        .Ai   (Ai),
        .Bi   (Bi),
        .Immi (Immi),
        .cond (cond),
        .ALUo (ALUo),
        .Bo   (Bo),
        .IRo  (IRo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".alu"},  ALUo, 32'h0);
        check({tag, ".cond"}, {31'h0, cond}, 32'h0);
        check({tag, ".bo"},   Bo,   32'h0);
        check({tag, ".ir"},   IRo,  32'h0);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] shamt);
        return {6'h00, 5'd1, 5'd2, 5'd3, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] sext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Drive one instruction at the falling edge, queue its expected result,
    // then pop and compare one edge later.
    task automatic send(input string tag,
                        input logic [31:0] ir, input logic [31:0] npc,
                        input logic [31:0] a,  input logic [31:0] b,
                        input logic [31:0] imm,
                        input logic [31:0] e_alu, input logic e_cond,
                        input logic [31:0] e_bo);
        exp_t e;
        @(negedge clk);
        IRi = ir; NPCi = npc; Ai = a; Bi = b; Immi = imm;
        sb_q.push_back('{tag, e_alu, e_cond, e_bo, ir});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".alu"},  ALUo, e.alu);
            check({e.tag, ".cond"}, {31'h0, cond}, {31'h0, e.cnd});
            check({e.tag, ".bo"},   Bo,   e.bo);
            check({e.tag, ".ir"},   IRo,  e.ir);
        end
    endtask

    initial begin
        rst = 1'b0;
        IRi = $urandom; NPCi = $urandom; Ai = $urandom; Bi = $urandom; Immi = $urandom;
        #2;
        check_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            IRi = $urandom; NPCi = $urandom; Ai = $urandom; Bi = $urandom; Immi = $urandom;
            check_zero("rst_hold");
        end
        rst = 1'b1;

        // nop after reset release
        send("nop", 32'h0, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 32'd7);

        // R-type arithmetic / logic / compare
        send("add",  32'h00221820, 32'h4, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h1, 1'b0, 32'd2);
        send("sub",  rtype(6'h22, 5'd0), 32'h4, 32'd3, 32'd5, 32'h0, 32'hFFFFFFFE, 1'b0, 32'd5);
        send("slt",  rtype(6'h2A, 5'd0), 32'h4, 32'd3, 32'd5, 32'h0, 32'h1, 1'b0, 32'd5);
        send("sltn", rtype(6'h2A, 5'd0), 32'h4, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h1, 1'b0, 32'd1);
        send("sltu", rtype(6'h2B, 5'd0), 32'h4, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b0, 32'd1);
        send("nor",  rtype(6'h27, 5'd0), 32'h4, 32'h0F0F0000, 32'h000000F0, 32'h0, 32'hF0F0FF0F, 1'b0, 32'h000000F0);
        send("xor",  rtype(6'h26, 5'd0), 32'h4, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'hF0F0F0F0, 1'b0, 32'h0FF00FF0);

        // shifts
        send("sra",  rtype(6'h03, 5'd4), 32'h4, 32'h0, 32'h80000000, 32'h0, 32'hF8000000, 1'b0, 32'h80000000);
        send("srl",  rtype(6'h02, 5'd4), 32'h4, 32'h0, 32'h80000000, 32'h0, 32'h08000000, 1'b0, 32'h80000000);
        send("sll",  rtype(6'h00, 5'd8), 32'h4, 32'h0, 32'h00000081, 32'h0, 32'h00008100, 1'b0, 32'h00000081);
        send("sllv", rtype(6'h04, 5'd0), 32'h4, 32'd36, 32'd1, 32'h0, 32'h10, 1'b0, 32'd1);
        send("srav", rtype(6'h07, 5'd0), 32'h4, 32'h00000104, 32'h80000000, 32'h0, 32'hF8000000, 1'b0, 32'h80000000);

        // I-type
        send("ori",   itype(6'h0D, 16'h8001), 32'h4, 32'h0, 32'h3, sext(16'h8001), 32'h00008001, 1'b0, 32'h3);
        send("andi",  itype(6'h0C, 16'h8001), 32'h4, 32'hFFFFFFFF, 32'h3, sext(16'h8001), 32'h00008001, 1'b0, 32'h3);
        send("lui",   itype(6'h0F, 16'h1234), 32'h4, 32'hAAAA5555, 32'h3, sext(16'h1234), 32'h12340000, 1'b0, 32'h3);
        send("addi",  itype(6'h08, 16'hFFFF), 32'h4, 32'd5, 32'h3, sext(16'hFFFF), 32'h4, 1'b0, 32'h3);
        send("sltiu", itype(6'h0B, 16'hFFFF), 32'h4, 32'd5, 32'h3, sext(16'hFFFF), 32'h1, 1'b0, 32'h3);
        send("slti",  itype(6'h0A, 16'hFFFF), 32'h4, 32'd5, 32'h3, sext(16'hFFFF), 32'h0, 1'b0, 32'h3);

        // branches
        send("beq_t", itype(6'h04, 16'hFFFE), 32'h100, 32'd9, 32'd9, 32'hFFFFFFFE, 32'hF8, 1'b1, 32'd9);
        send("beq_n", itype(6'h04, 16'hFFFE), 32'h100, 32'd9, 32'd8, 32'hFFFFFFFE, 32'hF8, 1'b0, 32'd8);
        send("bne_t", itype(6'h05, 16'hFFFE), 32'h100, 32'd9, 32'd8, 32'hFFFFFFFE, 32'hF8, 1'b1, 32'd8);

        // jumps
        send("jal", {6'h03, 26'h0000040}, 32'h40000008, 32'h0, 32'h55, 32'h40, 32'h40000100, 1'b1, 32'h40000008);
        send("j",   {6'h02, 26'h3FFFFFF}, 32'h80000004, 32'h0, 32'h55, 32'hFFFFFFFF, 32'h8FFFFFFC, 1'b1, 32'h55);
        send("jr",  rtype(6'h08, 5'd0), 32'h4, 32'h1234, 32'h66, 32'h0, 32'h1234, 1'b1, 32'h66);

        // undefined opcode and undefined funct
        send("bad_op", itype(6'h3F, 16'h1111), 32'h4, 32'h7, 32'h77, 32'h1111, 32'h0, 1'b0, 32'h77);
        send("bad_fn", rtype(6'h3F, 5'd3), 32'h4, 32'h7, 32'h78, 32'h0, 32'h0, 1'b0, 32'h78);

        // store, then reset asserted between edges
        send("sw", itype(6'h2B, 16'hFFFC), 32'h4, 32'h1000, 32'hAB, 32'hFFFFFFFC, 32'h00000FFC, 1'b0, 32'hAB);
        #2;
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        IRi = itype(6'h08, 16'h0001); Ai = 32'h10; Bi = 32'h20; Immi = 32'h1;
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        rst = 1'b1;

        send("post_rst", itype(6'h08, 16'h0001), 32'h4, 32'h10, 32'h20, 32'h1, 32'h11, 1'b0, 32'h20);

        if (sb_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ex_seg.md
EX_SEG -- requirements
Module: ex_seg

Interface
REQ-001 clk  input  1  rising-edge pipeline clock.
REQ-002 rst  input  1  reset, asynchronous, active-low; one clock domain only.
REQ-003 IRi  input  32  instruction from ID stage (MIPS-style R/I/J encoding: op=IRi[31:26], rs=[25:21], rt=[20:16], shamt=[10:6], funct=[5:0], imm=[15:0], target=[25:0]).
REQ-004 NPCi  input  32  PC+4 of this instruction.
REQ-005 Ai  input  32  rs register value.
REQ-006 Bi  input  32  rt register value.
REQ-007 Immi  input  32  sign-extended imm16, produced by ID.
REQ-008 cond  output  1  registered branch/jump-taken flag.
REQ-009 ALUo  output  32  registered ALU result, memory address, or jump/branch target.
REQ-010 Bo  output  32  registered store data or link value.
REQ-011 IRo  output  32  registered copy of IRi.

Function
REQ-012 All outputs SHALL be registered EX/MEM pipeline registers: inputs sampled on each rising clk edge; results visible after exactly 1 cycle; no stall or enable input; new result every cycle.
REQ-013 IRo SHALL equal IRi and Bo SHALL equal Bi, except for jal (REQ-020).
REQ-014 R-type (op=000000) SHALL compute ALUo by funct: add/addu (0x20/0x21)=A+B; sub/subu (0x22/0x23)=A-B; and 0x24; or 0x25; xor 0x26; nor 0x27; slt 0x2A signed A<B ? 1 : 0; sltu 0x2B unsigned.
REQ-015 Shifts SHALL compute: sll 0x00 = B<<shamt; srl 0x02 logical; sra 0x03 arithmetic; sllv/srlv/srav (0x04/0x06/0x07) use A[4:0] as the amount.
REQ-016 Arithmetic SHALL be 32-bit modulo 2^32: overflow wraps, no trap, no flag; cond=0 for all ALU ops.
REQ-017 I-type: addi 0x08/addiu 0x09 = A+Immi; slti 0x0A signed; sltiu 0x0B unsigned compare against Immi; andi 0x0C/ori 0x0D/xori 0x0E use zero-extended IRi[15:0]; lui 0x0F = {IRi[15:0],16'h0}; cond=0.
REQ-018 lw 0x23 / sw 0x2B SHALL give ALUo = A+Immi and cond=0.
REQ-019 beq 0x04 / bne 0x05 SHALL give ALUo = NPCi + (Immi<<2); cond = (A==B) for beq, (A!=B) for bne.
REQ-020 j 0x02 / jal 0x03 SHALL give ALUo = {NPCi[31:28], IRi[25:0], 2'b00} and cond=1; jal additionally sets Bo = NPCi (link value).
REQ-021 jr (op=0, funct 0x08) SHALL give ALUo = A and cond=1.
REQ-022 Any unlisted opcode/funct (including IRi=0, i.e. sll $0 nop, which yields 0) SHALL give ALUo=0 (except defined sll result) and cond=0, with IRo/Bo passed through.

Reset
REQ-023 While rst=0, cond, ALUo, Bo and IRo SHALL be 0, asynchronously and independent of clk.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result immediately; the first rising edge after release captures fresh inputs.

Verification
REQ-025 rst=0 with random inputs and clock running -> all outputs 0; release, apply IRi=0, Ai=5, Bi=7 -> after one edge ALUo=0, cond=0, Bo=7, IRo=0.
REQ-026 add (IRi=0x00221820), Ai=0xFFFFFFFF, Bi=2 -> ALUo=1, cond=0; sub with Ai=3, Bi=5 -> ALUo=0xFFFFFFFE; slt -> 1; sltu with Ai=0xFFFFFFFF, Bi=1 -> 0.
REQ-027 sra, shamt=4, Bi=0x80000000 -> ALUo=0xF8000000; srl -> 0x08000000; ori, imm=0x8001, Ai=0 -> 0x00008001; lui imm=0x1234 -> 0x12340000.
REQ-028 beq, NPCi=0x100, Immi=0xFFFFFFFE, Ai=Bi=9 -> ALUo=0xF8, cond=1; Bi=8 -> cond=0; bne, Bi=8 -> cond=1.
REQ-029 jal, target=0x0000040, NPCi=0x40000008 -> ALUo=0x40000100, cond=1, Bo=0x40000008; jr, Ai=0x1234 -> ALUo=0x1234, cond=1.
REQ-030 sw, Ai=0x1000, Immi=0xFFFFFFFC, Bi=0xAB -> ALUo=0x0FFC, Bo=0xAB; then assert rst between edges -> outputs drop to 0 before the next edge.
